// File: rtl/mem_wb_skid_pkg.sv
// Shared widths, NOP constants, state encoding and entry type for the MEM->WB skid register.
package mem_wb_skid_pkg;

    localparam int REG_W  = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic              WRITE_DISABLE = 1'b0;
    localparam logic [REG_W-1:0]  ZERO_WORD     = '0;

    // Encoding equals the number of held entries so occ can be taken straight from the state.
    typedef enum logic [1:0] {
        MEM_WB_EMPTY = 2'd0,
        MEM_WB_ONE   = 2'd1,
        MEM_WB_TWO   = 2'd2
    } mem_wb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [REG_W-1:0]  wdata;
    } mem_wb_entry_t;

    localparam mem_wb_entry_t NOP_ENTRY = '{wd: NOP_REG_ADDR, wreg: WRITE_DISABLE, wdata: ZERO_WORD};

endpackage

// File: rtl/mem_wb_skid_entry.sv
// One {wd, wreg, wdata} holding register with synchronous load and clear (clear wins).
module mem_wb_entry
    import mem_wb_skid_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clear,
    input  mem_wb_entry_t d,
    output mem_wb_entry_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= NOP_ENTRY;
        end else if (clear) begin
            q <= NOP_ENTRY;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// Elastic MEM->WB pipeline register: valid/ready handshake, 2-entry skid buffer, flush,
// and a saturating count of cycles the regfile write port held off a presented result.
//
//  state        | meaning
//  MEM_WB_EMPTY | nothing held, wb_valid=0, accepting
//  MEM_WB_ONE   | main entry on wb_*, still accepting
//  MEM_WB_TWO   | main on wb_*, skid holds the next result, not accepting
module mem_wb_skid
    import mem_wb_skid_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [REG_W-1:0]  mem_wdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [REG_W-1:0]  wb_wdata,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    mem_wb_state_e state_q, state_d;
    logic          ready_q;
    logic          in_fire, out_fire;
    logic          main_load, main_clear, main_from_skid;
    logic          skid_load, skid_clear;
    mem_wb_entry_t in_entry, main_d, main_q, skid_q;
    logic [CNT_W-1:0] stall_cnt_q;

    assign in_entry = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata};
    assign in_fire  = mem_valid & ready_q;
    assign out_fire = wb_valid & wb_ready;
    assign main_d   = main_from_skid ? skid_q : in_entry;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MEM_WB_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != MEM_WB_TWO);
        end
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_d    = MEM_WB_EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                MEM_WB_EMPTY: begin
                    if (in_fire) begin
                        state_d   = MEM_WB_ONE;
                        main_load = 1'b1;
                    end
                end
                MEM_WB_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d   = MEM_WB_TWO;
                        skid_load = 1'b1;
                    end else if (!in_fire && out_fire) begin
                        state_d    = MEM_WB_EMPTY;
                        main_clear = 1'b1;
                    end else if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end
                end
                MEM_WB_TWO: begin
                    if (out_fire) begin
                        state_d        = MEM_WB_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_d    = MEM_WB_EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    mem_wb_entry u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .q     (main_q)
    );

    mem_wb_entry u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_entry),
        .q     (skid_q)
    );

    // Counts regardless of flush; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (wb_valid && !wb_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign wb_valid  = (state_q != MEM_WB_EMPTY);
    assign mem_ready = ready_q;
    assign occ       = state_q;
    assign stall_cnt = stall_cnt_q;
    assign wb_wd     = wb_valid ? main_q.wd    : NOP_REG_ADDR;
    assign wb_wreg   = wb_valid ? main_q.wreg  : WRITE_DISABLE;
    assign wb_wdata  = wb_valid ? main_q.wdata : ZERO_WORD;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed bench for mem_wb_skid: reset, streaming, backpressure, simultaneous transfer,
// flush and stall counter saturation (DUT built with a 4-bit counter).
module tb_mem_wb_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [1:0]  occ;
    logic [3:0]  stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_wb_skid #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata),
        .occ       (occ),
        .stall_cnt (stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        mem_valid = v;
        mem_wd    = wd;
        mem_wreg  = wreg;
        mem_wdata = wdata;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush = 1'b0;
        wb_ready = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        flush = 1'b0;
        wb_ready = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        repeat (3) tick();
        n_cmp++; if (wb_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_wb_valid got %0h want 0", wb_valid); end
        n_cmp++; if (wb_wd !== 5'd0)      begin n_bad++; $display("FAIL reset_wb_wd got %0h want 0", wb_wd); end
        n_cmp++; if (wb_wdata !== 32'h0)  begin n_bad++; $display("FAIL reset_wb_wdata got %0h want 0", wb_wdata); end
        n_cmp++; if (wb_wreg !== 1'b0)    begin n_bad++; $display("FAIL reset_wb_wreg got %0h want 0", wb_wreg); end
        n_cmp++; if (mem_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_mem_ready got %0h want 1", mem_ready); end
        n_cmp++; if (occ !== 2'd0)        begin n_bad++; $display("FAIL reset_occ got %0d want 0", occ); end
        n_cmp++; if (stall_cnt !== 4'd0)  begin n_bad++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        rst = 1'b1;
        tick();
        // fill to two entries, then assert reset asynchronously mid-cycle
        drive(1'b1, 5'd9, 1'b1, 32'h99);
        tick();
        drive(1'b1, 5'd10, 1'b1, 32'hA0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        n_cmp++; if (occ !== 2'd2)        begin n_bad++; $display("FAIL async_pre_occ got %0d want 2", occ); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (occ !== 2'd0)        begin n_bad++; $display("FAIL async_rst_occ got %0d want 0", occ); end
        n_cmp++; if (wb_valid !== 1'b0)   begin n_bad++; $display("FAIL async_rst_wb_valid got %0h want 0", wb_valid); end
        n_cmp++; if (mem_ready !== 1'b1)  begin n_bad++; $display("FAIL async_rst_mem_ready got %0h want 1", mem_ready); end
        n_cmp++; if (stall_cnt !== 4'd0)  begin n_bad++; $display("FAIL async_rst_stall got %0d want 0", stall_cnt); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        do_reset();
        wb_ready = 1'b1;
        drive(1'b1, 5'd5, 1'b1, 32'h11);
        tick();
        n_cmp++; if (wb_valid !== 1'b1 || wb_wd !== 5'd5 || wb_wdata !== 32'h11 || wb_wreg !== 1'b1)
            begin n_bad++; $display("FAIL stream_first got v%0h wd%0d d%0h want v1 wd5 d11", wb_valid, wb_wd, wb_wdata); end
        n_cmp++; if (occ !== 2'd1) begin n_bad++; $display("FAIL stream_occ1 got %0d want 1", occ); end
        drive(1'b1, 5'd6, 1'b1, 32'h22);
        tick();
        n_cmp++; if (wb_valid !== 1'b1 || wb_wd !== 5'd6 || wb_wdata !== 32'h22)
            begin n_bad++; $display("FAIL stream_second got v%0h wd%0d d%0h want v1 wd6 d22", wb_valid, wb_wd, wb_wdata); end
        n_cmp++; if (occ !== 2'd1) begin n_bad++; $display("FAIL stream_occ2 got %0d want 1", occ); end
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        n_cmp++; if (wb_valid !== 1'b0 || occ !== 2'd0 || wb_wdata !== 32'h0)
            begin n_bad++; $display("FAIL stream_drain got v%0h occ%0d d%0h want v0 occ0 d0", wb_valid, occ, wb_wdata); end
    endtask

    task automatic test_backpressure();
        do_reset();
        wb_ready = 1'b0;
        drive(1'b1, 5'd1, 1'b1, 32'hAAAA);
        tick();
        n_cmp++; if (mem_ready !== 1'b1 || occ !== 2'd1)
            begin n_bad++; $display("FAIL bp_after_a got rdy%0h occ%0d want rdy1 occ1", mem_ready, occ); end
        drive(1'b1, 5'd2, 1'b1, 32'hBBBB);
        tick();
        n_cmp++; if (mem_ready !== 1'b0 || occ !== 2'd2)
            begin n_bad++; $display("FAIL bp_after_b got rdy%0h occ%0d want rdy0 occ2", mem_ready, occ); end
        drive(1'b1, 5'd3, 1'b1, 32'hCCCC);
        tick();
        tick();
        n_cmp++; if (occ !== 2'd2 || wb_wd !== 5'd1 || wb_wdata !== 32'hAAAA)
            begin n_bad++; $display("FAIL bp_hold got occ%0d wd%0d d%0h want occ2 wd1 dAAAA", occ, wb_wd, wb_wdata); end
        n_cmp++; if (stall_cnt !== 4'd3) begin n_bad++; $display("FAIL bp_stall_mid got %0d want 3", stall_cnt); end
        wb_ready = 1'b1;
        tick();
        n_cmp++; if (wb_wd !== 5'd2 || wb_wdata !== 32'hBBBB || occ !== 2'd1 || mem_ready !== 1'b1)
            begin n_bad++; $display("FAIL bp_b_out got wd%0d d%0h occ%0d rdy%0h want wd2 dBBBB occ1 rdy1", wb_wd, wb_wdata, occ, mem_ready); end
        tick();
        n_cmp++; if (wb_wd !== 5'd3 || wb_wdata !== 32'hCCCC || occ !== 2'd1)
            begin n_bad++; $display("FAIL bp_c_out got wd%0d d%0h occ%0d want wd3 dCCCC occ1", wb_wd, wb_wdata, occ); end
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        n_cmp++; if (wb_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain got v%0h want 0", wb_valid); end
        n_cmp++; if (stall_cnt !== 4'd3) begin n_bad++; $display("FAIL bp_stall_end got %0d want 3", stall_cnt); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        wb_ready = 1'b0;
        drive(1'b1, 5'd7, 1'b1, 32'h1234_5678);
        tick();
        wb_ready = 1'b1;
        drive(1'b1, 5'd8, 1'b0, 32'hDEAD_BEEF);
        tick();
        n_cmp++; if (occ !== 2'd1) begin n_bad++; $display("FAIL simul_occ got %0d want 1", occ); end
        n_cmp++; if (wb_wd !== 5'd8 || wb_wreg !== 1'b0 || wb_wdata !== 32'hDEAD_BEEF || wb_valid !== 1'b1)
            begin n_bad++; $display("FAIL simul_bubble got v%0h wd%0d we%0h d%0h want v1 wd8 we0 dDEADBEEF", wb_valid, wb_wd, wb_wreg, wb_wdata); end
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        n_cmp++; if (occ !== 2'd0) begin n_bad++; $display("FAIL simul_drain got %0d want 0", occ); end
    endtask

    task automatic test_flush();
        int seen;
        do_reset();
        wb_ready = 1'b0;
        drive(1'b1, 5'd11, 1'b1, 32'h5151);
        tick();
        drive(1'b1, 5'd12, 1'b1, 32'h5252);
        tick();
        flush = 1'b1;
        drive(1'b1, 5'd13, 1'b1, 32'h5353);
        tick();
        n_cmp++; if (occ !== 2'd0 || wb_valid !== 1'b0 || mem_ready !== 1'b1)
            begin n_bad++; $display("FAIL flush_state got occ%0d v%0h rdy%0h want occ0 v0 rdy1", occ, wb_valid, mem_ready); end
        n_cmp++; if (stall_cnt !== 4'd2) begin n_bad++; $display("FAIL flush_keeps_stall got %0d want 2", stall_cnt); end
        flush = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        wb_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wb_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL flush_no_delivery got %0d cycles valid want 0", seen); end
    endtask

    task automatic test_saturation();
        do_reset();
        wb_ready = 1'b0;
        drive(1'b1, 5'd4, 1'b1, 32'h4444);
        tick();
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        repeat (14) tick();
        n_cmp++; if (stall_cnt !== 4'd14) begin n_bad++; $display("FAIL sat_pre got %0d want 14", stall_cnt); end
        repeat (6) tick();
        n_cmp++; if (stall_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_20 got %0h want F", stall_cnt); end
        repeat (3) tick();
        n_cmp++; if (stall_cnt !== 4'hF) begin n_bad++; $display("FAIL sat_hold got %0h want F", stall_cnt); end
        n_cmp++; if (wb_wd !== 5'd4 || wb_wdata !== 32'h4444)
            begin n_bad++; $display("FAIL sat_stable got wd%0d d%0h want wd4 d4444", wb_wd, wb_wdata); end
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        wb_ready = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 32'h0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
